// File: rtl/mil_pkg.sv
// mil_pkg: shared MIL-STD-1553 command word fields, codes and state types.
package mil_pkg;

    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 11;
    localparam int TR_BIT   = 10;
    localparam int SA_MSB   = 9;
    localparam int SA_LSB   = 5;
    localparam int WC_MSB   = 4;
    localparam int WC_LSB   = 0;

    localparam logic [4:0] BCAST_ADDR = 5'd31;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_PARITY     = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_SUPERSEDED = 2'd3
    } err_code_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RX_DATA = 1'b1
    } state_e;

    // A word count field of 0 encodes a full 32-word message.
    function automatic logic [5:0] wc_to_count(input logic [4:0] wc);
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage

// File: rtl/mil_cmd_decode.sv
// mil_cmd_decode: combinational command word decode (address match, broadcast,
// receive-message detection, subaddress and expected data word count).
module mil_cmd_decode
    import mil_pkg::*;
#(
    parameter logic [4:0] RT_ADDR = 5'd1
) (
    input  logic [15:0] i_word,
    output logic        o_match,
    output logic        o_bcast,
    output logic        o_rx_msg,
    output logic [4:0]  o_sa,
    output logic [5:0]  o_expect
);

    logic [4:0] w_addr;
    logic [4:0] w_wc;
    logic       w_mode;

    assign w_addr   = i_word[ADDR_MSB:ADDR_LSB];
    assign w_wc     = i_word[WC_MSB:WC_LSB];
    assign o_sa     = i_word[SA_MSB:SA_LSB];
    assign o_bcast  = (w_addr == BCAST_ADDR);
    assign o_match  = (w_addr == RT_ADDR) || o_bcast;
    assign w_mode   = (o_sa == 5'd0) || (o_sa == 5'd31);
    assign o_rx_msg = !i_word[TR_BIT] && !w_mode;
    assign o_expect = wc_to_count(w_wc);

endmodule

// File: rtl/mil_rt_rx_ctrl.sv
// mil_rt_rx_ctrl: remote-terminal receive sequencer; decodes commands, steers
// data words into the subaddress buffer and reports completion/errors.
module mil_rt_rx_ctrl
    import mil_pkg::*;
#(
    parameter logic [4:0] RT_ADDR = 5'd1,
    parameter int         TMO_CLK = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_stb,
    input  logic [15:0] i_rx_dat,
    input  logic        i_rx_cw,
    input  logic        i_rx_par_ok,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_sa,
    output logic [4:0]  o_wr_addr,
    output logic [15:0] o_wr_dat,
    output logic        o_cmd_req,
    output logic [15:0] o_cmd_word,
    output logic        o_busy,
    output logic        o_msg_done,
    output logic        o_status_req,
    output logic        o_msg_err,
    output logic [1:0]  o_err_code
);

    localparam int TW = $clog2(TMO_CLK + 1);

    logic        w_match;
    logic        w_bcast;
    logic        w_rx_msg;
    logic [4:0]  w_sa;
    logic [5:0]  w_expect;
    logic        w_in_msg;

    state_e      r_state;
    err_code_e   r_err;
    logic [5:0]  r_cnt;
    logic [5:0]  r_expect;
    logic [4:0]  r_sa;
    logic        r_bcast;
    logic [TW-1:0] r_tmo;
    logic        r_wr_en;
    logic [4:0]  r_wr_sa;
    logic [4:0]  r_wr_addr;
    logic [15:0] r_wr_dat;
    logic        r_cmd_req;
    logic [15:0] r_cmd_word;
    logic        r_msg_done;
    logic        r_status_req;
    logic        r_msg_err;

    mil_cmd_decode #(.RT_ADDR(RT_ADDR)) u_dec (
        .i_word   (i_rx_dat),
        .o_match  (w_match),
        .o_bcast  (w_bcast),
        .o_rx_msg (w_rx_msg),
        .o_sa     (w_sa),
        .o_expect (w_expect)
    );

    assign w_in_msg = (r_state == ST_RX_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_err        <= ERR_NONE;
            r_cnt        <= '0;
            r_expect     <= '0;
            r_sa         <= '0;
            r_bcast      <= 1'b0;
            r_tmo        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_sa      <= '0;
            r_wr_addr    <= '0;
            r_wr_dat     <= '0;
            r_cmd_req    <= 1'b0;
            r_cmd_word   <= '0;
            r_msg_done   <= 1'b0;
            r_status_req <= 1'b0;
            r_msg_err    <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_cmd_req    <= 1'b0;
            r_msg_done   <= 1'b0;
            r_status_req <= 1'b0;
            r_msg_err    <= 1'b0;
            if (i_rx_stb) begin
                r_tmo <= '0;
                if (w_in_msg && !i_rx_par_ok) begin
                    r_msg_err <= 1'b1;
                    r_err     <= ERR_PARITY;
                    r_state   <= ST_IDLE;
                end else if (w_in_msg && !i_rx_cw) begin
                    r_wr_en   <= 1'b1;
                    r_wr_sa   <= r_sa;
                    r_wr_addr <= r_cnt[4:0];
                    r_wr_dat  <= i_rx_dat;
                    r_cnt     <= r_cnt + 6'd1;
                    if (r_cnt + 6'd1 == r_expect) begin
                        r_msg_done   <= 1'b1;
                        r_status_req <= !r_bcast;
                        r_state      <= ST_IDLE;
                    end
                end else begin
                    // A good command during a message aborts it and is then
                    // decoded exactly as if it had arrived in IDLE.
                    if (w_in_msg) begin
                        r_msg_err <= 1'b1;
                        r_err     <= ERR_SUPERSEDED;
                        r_state   <= ST_IDLE;
                    end
                    if (i_rx_cw && i_rx_par_ok && w_match) begin
                        r_cmd_word <= i_rx_dat;
                        if (w_rx_msg) begin
                            r_state  <= ST_RX_DATA;
                            r_cnt    <= '0;
                            r_expect <= w_expect;
                            r_sa     <= w_sa;
                            r_bcast  <= w_bcast;
                        end else begin
                            r_cmd_req    <= 1'b1;
                            r_status_req <= !w_bcast;
                        end
                    end
                end
            end else if (w_in_msg) begin
                if (r_tmo == TW'(TMO_CLK - 1)) begin
                    r_msg_err <= 1'b1;
                    r_err     <= ERR_TIMEOUT;
                    r_state   <= ST_IDLE;
                end else if (r_tmo != TW'(TMO_CLK)) begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_sa      = r_wr_sa;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_dat     = r_wr_dat;
    assign o_cmd_req    = r_cmd_req;
    assign o_cmd_word   = r_cmd_word;
    assign o_busy       = w_in_msg;
    assign o_msg_done   = r_msg_done;
    assign o_status_req = r_status_req;
    assign o_msg_err    = r_msg_err;
    assign o_err_code   = r_err;

endmodule

// File: tb/tb_mil_rt_rx_ctrl.sv
// tb_mil_rt_rx_ctrl: scoreboard bench; a message-level model predicts every
// output pulse event, a negedge monitor pops and compares them.
module tb_mil_rt_rx_ctrl;

    localparam int TMO = 64;

    typedef struct packed {
        int          cyc;
        logic        wr_en;
        logic [4:0]  sa;
        logic [4:0]  addr;
        logic [15:0] dat;
        logic        done;
        logic        sreq;
        logic        err;
        logic [1:0]  code;
        logic        creq;
        logic [15:0] cw;
        logic        busy;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_stb = 1'b0;
    logic [15:0] rx_dat = '0;
    logic        rx_cw = 1'b0;
    logic        rx_par_ok = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_sa;
    logic [4:0]  wr_addr;
    logic [15:0] wr_dat;
    logic        cmd_req;
    logic [15:0] cmd_word;
    logic        busy;
    logic        msg_done;
    logic        status_req;
    logic        msg_err;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    ev_t q[$];

    bit          m_in = 0;
    int          m_got = 0;
    int          m_exp = 0;
    logic [4:0]  m_sa = '0;
    bit          m_bc = 0;
    logic [15:0] m_cw = '0;
    logic [1:0]  m_err = '0;

    mil_rt_rx_ctrl #(.RT_ADDR(5'd3), .TMO_CLK(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_stb    (rx_stb),
        .i_rx_dat    (rx_dat),
        .i_rx_cw     (rx_cw),
        .i_rx_par_ok (rx_par_ok),
        .o_wr_en     (wr_en),
        .o_wr_sa     (wr_sa),
        .o_wr_addr   (wr_addr),
        .o_wr_dat    (wr_dat),
        .o_cmd_req   (cmd_req),
        .o_cmd_word  (cmd_word),
        .o_busy      (busy),
        .o_msg_done  (msg_done),
        .o_status_req(status_req),
        .o_msg_err   (msg_err),
        .o_err_code  (err_code)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d wr=%0b sa=%0d a=%0d d=%h done=%0b sreq=%0b err=%0b code=%0d creq=%0b cw=%h busy=%0b",
            e.cyc, e.wr_en, e.sa, e.addr, e.dat, e.done, e.sreq, e.err, e.code, e.creq, e.cw, e.busy);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        ev_t o;
        ev_t e;
        if (!rst && (wr_en || msg_done || msg_err || cmd_req || status_req)) begin
            o = '0;
            o.cyc = cyc;
            o.wr_en = wr_en;
            o.sa = wr_en ? wr_sa : 5'd0;
            o.addr = wr_en ? wr_addr : 5'd0;
            o.dat = wr_en ? wr_dat : 16'd0;
            o.done = msg_done;
            o.sreq = status_req;
            o.err = msg_err;
            o.code = err_code;
            o.creq = cmd_req;
            o.cw = cmd_word;
            o.busy = busy;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected event: got %s want none", fmt(o));
            end else begin
                e = q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL event: got %s want %s", fmt(o), fmt(e));
                end
            end
        end
    end

    // Message-level reference: applies the receive rules to one word sampled at edge k.
    task automatic model_word(input logic cw, input logic par, input logic [15:0] d, input int k);
        ev_t e;
        logic [4:0] a;
        logic [4:0] sa;
        e = '0;
        e.cyc = k;
        a = d[15:11];
        sa = d[9:5];
        if (m_in) begin
            if (!par) begin
                m_in = 0; m_err = 2'd1; e.err = 1'b1;
            end else if (!cw) begin
                e.wr_en = 1'b1; e.sa = m_sa; e.addr = m_got[4:0]; e.dat = d;
                m_got++;
                if (m_got == m_exp) begin
                    m_in = 0; e.done = 1'b1; e.sreq = !m_bc;
                end
            end else begin
                m_in = 0; m_err = 2'd3; e.err = 1'b1;
            end
        end
        if (cw && par && (a == 5'd3 || a == 5'd31)) begin
            m_cw = d;
            if (!d[10] && sa != 5'd0 && sa != 5'd31) begin
                m_in = 1; m_sa = sa; m_bc = (a == 5'd31); m_got = 0;
                m_exp = (d[4:0] == 5'd0) ? 32 : int'(d[4:0]);
            end else begin
                e.creq = 1'b1; e.sreq = (a != 5'd31);
            end
        end
        e.cw = m_cw;
        e.code = m_err;
        e.busy = m_in;
        if (e.wr_en || e.done || e.err || e.creq || e.sreq) q.push_back(e);
    endtask

    task automatic predict_tmo(input int k, input int gap);
        ev_t e;
        if (m_in && gap >= TMO) begin
            m_in = 0;
            m_err = 2'd2;
            e = '0;
            e.cyc = k + TMO;
            e.err = 1'b1;
            e.code = m_err;
            e.cw = m_cw;
            q.push_back(e);
        end
    endtask

    // Called at a negedge; the strobe is sampled at the next posedge (edge cyc+1).
    task automatic send(input logic cw, input logic par, input logic [15:0] d, input int gap);
        int k;
        k = cyc + 1;
        rx_stb = 1'b1; rx_cw = cw; rx_par_ok = par; rx_dat = d;
        model_word(cw, par, d, k);
        predict_tmo(k, gap);
        @(negedge clk);
        rx_stb = 1'b0; rx_cw = 1'b0; rx_par_ok = 1'b0; rx_dat = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input int k);
        predict_tmo(k, TMO);
        repeat (TMO + 8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] w;
        int g;
        int r;
        int last_k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset cmd_word", {16'd0, cmd_word}, 32'd0);
        chk("reset err_code", {30'd0, err_code}, 32'd0);
        chk("reset pulses", {27'd0, wr_en, cmd_req, msg_done, status_req, msg_err}, 32'd0);

        send(1, 1, 16'h1843, 3);
        send(0, 1, 16'hAAAA, 3);
        send(0, 1, 16'h5555, 3);
        send(0, 1, 16'h0F0F, 5);

        send(1, 1, 16'hF843, 2);
        send(0, 1, 16'h1111, 0);
        send(0, 1, 16'h2222, 0);
        send(0, 1, 16'h3333, 4);

        send(1, 1, 16'h1840, 2);
        for (int i = 0; i < 33; i++) send(0, 1, 16'(i * 16'h0101 + 16'h7), 1);
        repeat (3) @(negedge clk);

        send(1, 1, 16'h1843, 2);
        send(0, 1, 16'hBEEF, TMO + 4);

        send(1, 1, 16'h1843, 2);
        send(0, 1, 16'h1234, TMO - 1);
        send(0, 1, 16'h5678, 3);
        send(1, 1, 16'h1C41, 4);

        send(1, 1, 16'h1843, 2);
        send(0, 1, 16'hCAFE, 2);
        send(0, 0, 16'hDEAD, 4);

        send(1, 1, 16'h1842, 2);
        send(0, 1, 16'hF00D, 2);
        rst = 1'b1;
        m_in = 0; m_cw = '0; m_err = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        chk("rst mid cmd_word", {16'd0, cmd_word}, 32'd0);
        chk("rst mid err_code", {30'd0, err_code}, 32'd0);

        last_k = 0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            w = 16'($urandom);
            if (r <= 2) begin
                g = $urandom_range(0, 3);
                w[15:11] = (g == 0) ? 5'd31 : (g == 1) ? 5'(w[15:11]) : 5'd3;
                w[10] = ($urandom_range(0, 3) == 0);
                w[4:0] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 5));
            end
            r = (r <= 2) ? 1 : (r == 9) ? int'($urandom_range(0, 1)) : 0;
            g = $urandom_range(0, 19);
            g = (g == 0) ? TMO - 1 : (g == 1) ? TMO : (g == 2) ? TMO + 3 : int'($urandom_range(0, 4));
            last_k = cyc + 1;
            send(r[0], $urandom_range(0, 19) != 0, w, g);
        end
        drain(last_k);

        chk("scoreboard drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
